dct8_mac_sequencer: RTL

- Time-multiplexed 8-point 1-D DCT engine. It shares one `lut_multiplier` (the existing fabric-only fixed-point multiplier) across all 64 coefficient products of a row.
- Accepts one 8-sample vector via valid/ready, runs a multiply-accumulate over a constant cosine ROM, and streams 8 saturated coefficients out via valid/ready.
- Sits between the row buffer and the transpose stage of the DCT path, as the low-area alternative to the parallel butterfly.

---
 rtl/dct_pkg.sv | 45 ++++
 rtl/lut_multiplier.sv | 35 +++
 rtl/dct8_mac_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// dct_pkg: shared constants and types for the 8-point DCT sequencer.
//   DCT_N    : transform length (8 samples in, 8 coefficients out)
//   COEF_W   : width of the stored cosine coefficients (Q1.15 signed)
//   state_t  : sequencer FSM states (IDLE / MAC / OUT)
//   COEF_MAG : |round(2^15 * c(j)/2 * cos(j*pi/16))|, with index 0 holding the
//              k=0 DC weight (c(0)=1/sqrt(2))
//   DCT_ROM  : signed C[k][n], flattened as index {k,n} = k*8+n
package dct_pkg;

  localparam int DCT_N  = 8;
  localparam int COEF_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  localparam logic signed [COEF_W-1:0] COEF_MAG [DCT_N] = '{
    16'sd11585, 16'sd16069, 16'sd15137, 16'sd13623,
    16'sd11585, 16'sd9102,  16'sd6270,  16'sd3196
  };

  // Row k uses cos((2n+1)k*pi/16); each entry reduces that angle to a
  // magnitude COEF_MAG[j] and the DCT-II sign pattern.
  localparam logic signed [COEF_W-1:0] DCT_ROM [DCT_N*DCT_N] = '{
    COEF_MAG[0],  COEF_MAG[0],  COEF_MAG[0],  COEF_MAG[0],
    COEF_MAG[0],  COEF_MAG[0],  COEF_MAG[0],  COEF_MAG[0],
    COEF_MAG[1],  COEF_MAG[3],  COEF_MAG[5],  COEF_MAG[7],
    -COEF_MAG[7], -COEF_MAG[5], -COEF_MAG[3], -COEF_MAG[1],
    COEF_MAG[2],  COEF_MAG[6],  -COEF_MAG[6], -COEF_MAG[2],
    -COEF_MAG[2], -COEF_MAG[6], COEF_MAG[6],  COEF_MAG[2],
    COEF_MAG[3],  -COEF_MAG[7], -COEF_MAG[1], -COEF_MAG[5],
    COEF_MAG[5],  COEF_MAG[1],  COEF_MAG[7],  -COEF_MAG[3],
    COEF_MAG[4],  -COEF_MAG[4], -COEF_MAG[4], COEF_MAG[4],
    COEF_MAG[4],  -COEF_MAG[4], -COEF_MAG[4], COEF_MAG[4],
    COEF_MAG[5],  -COEF_MAG[1], COEF_MAG[7],  COEF_MAG[3],
    -COEF_MAG[3], -COEF_MAG[7], COEF_MAG[1],  -COEF_MAG[5],
    COEF_MAG[6],  -COEF_MAG[2], COEF_MAG[2],  -COEF_MAG[6],
    -COEF_MAG[6], COEF_MAG[2],  -COEF_MAG[2], COEF_MAG[6],
    COEF_MAG[7],  -COEF_MAG[5], COEF_MAG[3],  -COEF_MAG[1],
    COEF_MAG[1],  -COEF_MAG[3], COEF_MAG[5],  -COEF_MAG[7]
  };

endpackage

// File: rtl/lut_multiplier.sv
// lut_multiplier: combinational signed fixed-point multiplier built from
// shift-and-add partial products so it maps onto fabric logic only.
//   a : signed sample, IN_W bits
//   b : signed coefficient, CONST_W bits, FRAC fractional bits
//   p : (a*b) >>> FRAC, truncated to IN_W bits (floor, no rounding)
module lut_multiplier #(
  parameter int IN_W    = 32,
  parameter int CONST_W = 16,
  parameter int FRAC    = 15
) (
  input  logic [IN_W-1:0]    a,
  input  logic [CONST_W-1:0] b,
  output logic [IN_W-1:0]    p
);

  localparam int FULL_W = IN_W + CONST_W;

  logic signed [FULL_W-1:0] a_ext;
  logic signed [FULL_W-1:0] full;

  // The coefficient MSB carries weight -2^(CONST_W-1), so its partial
  // product is subtracted instead of added.
  always_comb begin
    a_ext = FULL_W'($signed(a));
    full  = '0;
    for (int i = 0; i < CONST_W; i++) begin
      if (b[i]) begin
        if (i == CONST_W - 1) full = full - (a_ext <<< i);
        else                  full = full + (a_ext <<< i);
      end
    end
    p = IN_W'(full >>> FRAC);
  end

endmodule

// File: rtl/dct8_mac_sequencer.sv
// dct8_mac_sequencer: time-multiplexed 8-point 1-D DCT-II. One shared
// lut_multiplier performs all 64 products of a row, one per cycle; the
// accumulator is saturated to IN_W bits once per coefficient.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : input vector handshake, in_data = x[0..7]
//   out_valid/out_ready  : coefficient handshake
//   out_data             : saturated X[k]
//   out_idx, out_last    : k of the presented coefficient, high on k==7
//   busy                 : high whenever the FSM is not IDLE
module dct8_mac_sequencer
  import dct_pkg::*;
#(
  parameter int IN_W    = 32,
  parameter int CONST_W = 16,
  parameter int FRAC    = 15,
  parameter int GUARD   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8*IN_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IN_W-1:0]   out_data,
  output logic [2:0]        out_idx,
  output logic              out_last,
  output logic              busy
);

  localparam int         ACC_W = IN_W + GUARD;
  localparam logic [2:0] LAST  = 3'(DCT_N - 1);

  state_t                     state_q, state_d;
  logic [DCT_N-1:0][IN_W-1:0] x_q, x_d;
  logic [2:0]                 k_q, k_d;
  logic [2:0]                 n_q, n_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [IN_W-1:0]            out_data_q, out_data_d;

  logic signed [ACC_W-1:0]    acc_sum;
  logic [IN_W-1:0]            sat_sum;
  logic [CONST_W-1:0]         coef;
  logic [IN_W-1:0]            prod;

  assign coef = CONST_W'(DCT_ROM[{k_q, n_q}]);

  lut_multiplier #(
    .IN_W   (IN_W),
    .CONST_W(CONST_W),
    .FRAC   (FRAC)
  ) u_mult (
    .a(x_q[n_q]),
    .b(coef),
    .p(prod)
  );

  // The sum fits IN_W bits only when all guard bits equal the IN_W sign bit;
  // otherwise clamp towards the sign of the wide sum.
  always_comb begin
    acc_sum = acc_q + ACC_W'($signed(prod));
    if (acc_sum[ACC_W-1:IN_W-1] == {(GUARD+1){acc_sum[ACC_W-1]}})
      sat_sum = acc_sum[IN_W-1:0];
    else if (acc_sum[ACC_W-1])
      sat_sum = {1'b1, {(IN_W-1){1'b0}}};
    else
      sat_sum = {1'b0, {(IN_W-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = MAC;
      MAC:     if (n_q == LAST) state_d = OUT;
      OUT:     if (out_ready) state_d = (k_q == LAST) ? IDLE : MAC;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q        <= '0;
      k_q        <= '0;
      n_q        <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      x_q        <= x_d;
      k_q        <= k_d;
      n_q        <= n_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
    end
  end

  // The last product of a row goes straight into the saturated result, so
  // out_data is ready the same edge the FSM enters OUT.
  always_comb begin
    x_d        = x_q;
    k_d        = k_q;
    n_d        = n_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d   = in_data;
          k_d   = '0;
          n_d   = '0;
          acc_d = '0;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        n_d   = n_q + 3'd1;
        if (n_q == LAST) out_data_d = sat_sum;
      end
      OUT: begin
        if (out_ready) begin
          acc_d = '0;
          n_d   = '0;
          k_d   = (k_q == LAST) ? 3'd0 : k_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
    out_last  = (state_q == OUT) && (k_q == LAST);
    out_idx   = k_q;
    out_data  = out_data_q;
  end

endmodule
